// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    TURN = 2'b10
  } arb_state_t;

  // Increment modulo n, for indices that are not a power of two wide.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bounded tenure and a one-cycle turnaround between owners.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = $clog2(N),
  localparam int CW       = $clog2(MAX_HOLD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          done,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] owner,
  output logic          busy,
  output logic          timeout
);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [IW-1:0] pick_idx;
  logic          pick_valid;
  logic          at_limit;
  logic          owner_req;
  logic          release_now;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign at_limit    = (cnt_q == CW'(MAX_HOLD - 1));
  assign owner_req   = req[owner_q];
  assign release_now = done || !owner_req || at_limit;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d   = TURN;
          // The limit only flags a timeout when the owner would otherwise keep going.
          timeout_d = at_limit && !done && owner_req;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TURN: begin
        ptr_d   = IW'(wrap_inc(int'(owner_q), N));
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs decode purely from registers; inputs never reach them combinationally.
  always_comb begin
    gnt = '0;
    if (state_q == BUSY) gnt[owner_q] = 1'b1;
  end

  assign busy    = (state_q == BUSY);
  assign owner   = owner_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed scenarios plus randomized traffic against a tenure-level model.
module tb_rr_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         done;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout)
  );

  // Tenure-level model: who holds the resource, how many cycles it has held it,
  // whether we are in the gap after a tenure, and where the search starts next.
  bit m_busy, m_turn, m_to;
  int m_owner, m_ptr, m_held;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_turn = 0; m_to = 0;
    m_owner = 0; m_ptr = 0; m_held = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] r, input logic d);
    bit limit;
    if (m_turn) begin
      m_turn = 0;
      m_to   = 0;
      m_ptr  = (m_owner + 1) % N;
    end else if (m_busy) begin
      m_held++;
      limit = (m_held == MAX_HOLD);
      if (d || !r[m_owner] || limit) begin
        m_busy = 0;
        m_turn = 1;
        m_to   = limit && !d && r[m_owner];
      end
    end else if (r != '0) begin
      m_owner = first_from(r, m_ptr);
      m_busy  = 1;
      m_held  = 0;
    end
  endtask

  task automatic compare_all();
    check("gnt", gnt, m_busy ? (32'd1 << m_owner) : 32'd0);
    check("busy", busy, m_busy);
    check("owner", owner, m_owner);
    check("timeout", timeout, m_turn && m_to);
  endtask

  // Inputs are driven at the falling edge; the model advances with the rising edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge(req, done);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] gq[$];
    int           lenq[$];
    int           gapq[$];
    int           len, gap;
    bit           prev_busy;
    int           exp_order[5] = '{0, 1, 2, 3, 0};

    model_reset();
    rst  = 1'b1;
    req  = 4'b1111;
    done = 1'b0;

    // Reset held with all requests pending, then the first grant goes to 0.
    repeat (3) step();
    rst = 1'b0;
    step();
    check("first_gnt", gnt, 4'b0001);

    // Single request with a done pulse.
    do_reset();
    req = 4'b0000;
    step();
    step();
    req = 4'b0100;
    step();
    check("single_gnt", gnt, 4'b0100);
    step();
    step();
    done = 1'b1;
    step();
    check("single_turn_gnt", gnt, 4'b0000);
    done = 1'b0;
    req  = 4'b0000;
    step();
    check("single_idle_busy", busy, 1'b0);

    // Fairness: all requesting, each owner releases on its second cycle.
    do_reset();
    req = 4'b1111;
    prev_busy = 1'b0;
    len = 0;
    gap = 0;
    for (int cyc = 0; cyc < 40 && gq.size() < 6; cyc++) begin
      done = m_busy && (m_held == 1);
      step();
      if (busy) begin
        if (!prev_busy) begin
          gq.push_back(gnt);
          if (gq.size() > 1) gapq.push_back(gap);
          len = 0;
        end
        len++;
      end else begin
        if (prev_busy) begin
          lenq.push_back(len);
          gap = 0;
        end
        gap++;
      end
      prev_busy = busy;
    end
    done = 1'b0;
    check("fair_count", (gq.size() >= 5), 1'b1);
    for (int i = 0; i < 5 && i < gq.size(); i++)
      check($sformatf("fair_order%0d", i), gq[i], 32'd1 << exp_order[i]);
    for (int i = 0; i < 4 && i < lenq.size(); i++)
      check($sformatf("fair_tenure%0d", i), lenq[i], 2);
    for (int i = 0; i < 4 && i < gapq.size(); i++)
      check($sformatf("fair_gap%0d", i), gapq[i], 2);

    // Timeout: a lone holder that never releases.
    do_reset();
    req  = 4'b0010;
    done = 1'b0;
    step();
    len = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      len++;
      step();
    end
    check("to_len", len, MAX_HOLD);
    check("to_pulse", timeout, 1'b1);
    step();
    check("to_clear", timeout, 1'b0);
    check("to_idle", busy, 1'b0);
    step();
    check("to_regrant", gnt, 4'b0010);

    // Limit coincides with done and a dropped request.
    do_reset();
    req = 4'b0010;
    step();
    for (int i = 0; i < 10 && m_held < MAX_HOLD - 1; i++) step();
    done = 1'b1;
    req  = 4'b0000;
    step();
    check("sim_timeout", timeout, 1'b0);
    check("sim_turn_busy", busy, 1'b0);
    done = 1'b0;
    step();
    check("sim_idle_timeout", timeout, 1'b0);
    step();
    check("sim_stay_idle", busy, 1'b0);

    // Reset mid-tenure drops the grant at once and restores ptr.
    do_reset();
    req = 4'b1000;
    step();
    check("mid_gnt", gnt, 4'b1000);
    step();
    #2 rst = 1'b1;
    #1;
    check("mid_async_gnt", gnt, 4'b0000);
    check("mid_async_busy", busy, 1'b0);
    model_reset();
    step();
    rst = 1'b0;
    req = 4'b1001;
    step();
    check("mid_regrant", gnt, 4'b0001);

    // Randomized traffic with occasional reset pulses.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 9) < 3) req = N'($urandom_range(0, 15));
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end
    rst  = 1'b0;
    done = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
